// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the pattern scan controller and its
// serial 10110 detector.
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DRAIN,
        ST_DONE
    } scan_state_e;

    localparam logic [4:0] PATTERN = 5'b10110;

    // Detector states are named by the longest pattern prefix seen so far.
    typedef enum logic [2:0] {
        DET_S0,
        DET_S1,
        DET_S10,
        DET_S101,
        DET_S1011
    } det_state_e;

endpackage

// File: rtl/pattern_scan_ctrl_det.sv
// Bit-serial overlapping 10110 detector: Mealy transitions with a
// registered match output, so a match on bit k is visible one cycle later.
module seq_det_10110
    import pattern_scan_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic in,
    output logic op
);

    det_state_e state_q, state_d;
    logic       op_q, op_d;

    always_comb begin
        state_d = state_q;
        op_d    = 1'b0;
        if (en) begin
            case (state_q)
                DET_S0:    state_d = in ? DET_S1    : DET_S0;
                DET_S1:    state_d = in ? DET_S1    : DET_S10;
                DET_S10:   state_d = in ? DET_S101  : DET_S0;
                DET_S101:  state_d = in ? DET_S1011 : DET_S10;
                DET_S1011: begin
                    // A completed match leaves the trailing "10" as the new prefix.
                    state_d = in ? DET_S1 : DET_S10;
                    op_d    = (in == PATTERN[0]);
                end
                default:   state_d = DET_S0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q <= DET_S0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    assign op = op_q;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Round-robin front end that serialises one requester word at a time through
// a shared 10110 detector and reports match count and end-position mask.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter  int NREQ   = 4,
    parameter  int WORD_W = 16,
    localparam int ID_W   = $clog2(NREQ),
    localparam int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*WORD_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic [CNT_W-1:0]       res_count,
    output logic [WORD_W-1:0]      res_mask,
    output logic                   busy
);

    scan_state_e         state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [WORD_W-1:0]   mask_q, mask_d;

    logic [WORD_W-1:0]   words [NREQ];
    logic [NREQ-1:0]     grant;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     arb_idx;
    logic                grant_any;
    logic                det_clr, det_en, det_op;

    for (genvar g = 0; g < NREQ; g++) begin : g_words
        assign words[g] = req_data[g*WORD_W +: WORD_W];
    end

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        arb_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            arb_idx = ID_W'((32'(rr_ptr_q) + i) % NREQ);
            if (!grant_any && req_valid[arb_idx]) begin
                grant_any = 1'b1;
                grant_id  = arb_idx;
            end
        end
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        id_d      = id_q;
        count_d   = count_q;
        mask_d    = mask_q;
        req_ready = '0;
        res_valid = 1'b0;
        det_clr   = 1'b0;
        det_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rst) begin
                    req_ready = grant;
                end
                if (grant_any) begin
                    shreg_d   = words[grant_id];
                    id_d      = grant_id;
                    rr_ptr_d  = ID_W'((32'(grant_id) + 1) % NREQ);
                    bit_cnt_d = '0;
                    count_d   = '0;
                    mask_d    = '0;
                    det_clr   = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                det_en    = 1'b1;
                shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                // The mask fills MSB-first as ops arrive one cycle behind their bits.
                if (bit_cnt_q != '0) begin
                    count_d = count_q + CNT_W'(det_op);
                    mask_d  = {mask_q[WORD_W-2:0], det_op};
                end
                if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                count_d = count_q + CNT_W'(det_op);
                mask_d  = {mask_q[WORD_W-2:0], det_op};
                state_d = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            id_q      <= '0;
            count_q   <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            id_q      <= id_d;
            count_q   <= count_d;
            mask_q    <= mask_d;
        end
    end

    seq_det_10110 u_det (
        .clk (clk),
        .rst (rst),
        .clr (det_clr),
        .en  (det_en),
        .in  (shreg_q[WORD_W-1]),
        .op  (det_op)
    );

    assign res_id    = id_q;
    assign res_count = count_q;
    assign res_mask  = mask_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Randomised self-checking bench for pattern_scan_ctrl with a sliding-window
// match model and a round-robin grant model.
module tb_pattern_scan_ctrl;

    localparam int NREQ  = 4;
    localparam int W     = 16;
    localparam int ID_W  = 2;
    localparam int CNT_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic              res_ready;
    logic [ID_W-1:0]   res_id;
    logic [CNT_W-1:0]  res_count;
    logic [W-1:0]      res_mask;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;
    int model_ptr = 0;

    always #5 clk = ~clk;

    pattern_scan_ctrl #(.NREQ(NREQ), .WORD_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_count (res_count),
        .res_mask  (res_mask),
        .busy      (busy)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b0;
        tick;
        tick;
        rst       = 1'b0;
        model_ptr = 0;
    endtask

    task automatic set_word(input int idx, input logic [W-1:0] w);
        req_data[idx*W +: W] = w;
    endtask

    // Every 5-bit window of the word read MSB-first; a hit ends at bit 15-k.
    function automatic void ref_scan(input logic [W-1:0] w, output int cnt, output logic [W-1:0] m);
        logic [4:0] win;
        cnt = 0;
        m   = '0;
        for (int k = 4; k < W; k++) begin
            for (int j = 0; j < 5; j++) win[4-j] = w[W-1-(k-4+j)];
            if (win == 5'b10110) begin
                cnt++;
                m[W-1-k] = 1'b1;
            end
        end
    endfunction

    function automatic int ref_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    // Drives one transaction and returns what the DUT produced; lat is the
    // cycle index (accept edge = cycle 0) in which res_valid is first high.
    task automatic run_word(input logic [NREQ-1:0] vmask, input logic ack,
                            output logic [NREQ-1:0] gvec, output logic [ID_W-1:0] id,
                            output logic [CNT_W-1:0] cnt, output logic [W-1:0] m,
                            output int lat, output logic ok);
        int waited;
        ok = 1'b1; gvec = '0; id = '0; cnt = '0; m = '0; lat = 0;
        req_valid = vmask;
        res_ready = ack;
        #1;
        waited = 0;
        while (!(|(req_ready & req_valid)) && waited < 40) begin
            tick;
            waited++;
        end
        if (!(|(req_ready & req_valid))) begin
            ok = 1'b0;
            return;
        end
        gvec = req_ready;
        tick;
        lat = 1;
        while (!res_valid && lat < 60) begin
            tick;
            lat++;
        end
        if (!res_valid) begin
            ok = 1'b0;
            return;
        end
        id  = res_id;
        cnt = res_count;
        m   = res_mask;
        if (ack) tick;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_data  = '0;
        res_ready = 1'b0;
        tick;
        tick;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if ({res_id, res_count, res_mask} !== '0) begin n_fail++; $display("FAIL reset_res_fields got id=%0d cnt=%0d mask=%h exp 0", res_id, res_count, res_mask); end
        rst       = 1'b0;
        req_valid = '0;
        tick;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_no_req got=%b exp=0000", req_ready); end
        req_valid = 4'b1111;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_rr_ptr got=%b exp=0001", req_ready); end
        req_valid = '0;
        model_ptr = 0;
    endtask

    task automatic test_vectors;
        logic [NREQ-1:0] g; logic [ID_W-1:0] id; logic [CNT_W-1:0] c; logic [W-1:0] m; int lat; logic ok;
        apply_reset;
        set_word(0, 16'hB600);
        run_word(4'b0001, 1'b1, g, id, c, m, lat, ok);
        req_valid = '0;
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL v1_timeout got=%b exp=1", ok); end
        n_checks++; if (id !== 2'd0) begin n_fail++; $display("FAIL v1_id got=%0d exp=0", id); end
        n_checks++; if (c !== 5'd2) begin n_fail++; $display("FAIL v1_count got=%0d exp=2", c); end
        n_checks++; if (m !== 16'h0900) begin n_fail++; $display("FAIL v1_mask got=%h exp=0900", m); end
        n_checks++; if (lat != 18) begin n_fail++; $display("FAIL v1_latency got=%0d exp=18", lat); end

        set_word(1, 16'b0101_0111_0111_0110);
        run_word(4'b0010, 1'b1, g, id, c, m, lat, ok);
        req_valid = '0;
        n_checks++; if ({ok, id, c, m} !== {1'b1, 2'd1, 5'd1, 16'h0001}) begin n_fail++; $display("FAIL v2 got ok=%b id=%0d cnt=%0d mask=%h exp 1/1/1/0001", ok, id, c, m); end

        set_word(2, 16'h0000);
        run_word(4'b0100, 1'b1, g, id, c, m, lat, ok);
        req_valid = '0;
        n_checks++; if ({ok, id, c, m} !== {1'b1, 2'd2, 5'd0, 16'h0000}) begin n_fail++; $display("FAIL v3_zero got ok=%b id=%0d cnt=%0d mask=%h exp 1/2/0/0000", ok, id, c, m); end

        set_word(3, 16'hFFFF);
        run_word(4'b1000, 1'b1, g, id, c, m, lat, ok);
        req_valid = '0;
        n_checks++; if ({ok, id, c, m} !== {1'b1, 2'd3, 5'd0, 16'h0000}) begin n_fail++; $display("FAIL v3_ones got ok=%b id=%0d cnt=%0d mask=%h exp 1/3/0/0000", ok, id, c, m); end
    endtask

    task automatic test_cross_word;
        logic [NREQ-1:0] g; logic [ID_W-1:0] id; logic [CNT_W-1:0] c; logic [W-1:0] m; int lat; logic ok;
        apply_reset;
        set_word(0, 16'h000B);
        run_word(4'b0001, 1'b1, g, id, c, m, lat, ok);
        req_valid = '0;
        n_checks++; if ({ok, c, m} !== {1'b1, 5'd0, 16'h0000}) begin n_fail++; $display("FAIL cross_first got ok=%b cnt=%0d mask=%h exp 1/0/0000", ok, c, m); end
        set_word(0, 16'h0000);
        run_word(4'b0001, 1'b1, g, id, c, m, lat, ok);
        req_valid = '0;
        n_checks++; if ({ok, c, m} !== {1'b1, 5'd0, 16'h0000}) begin n_fail++; $display("FAIL cross_second got ok=%b cnt=%0d mask=%h exp 1/0/0000", ok, c, m); end
    endtask

    task automatic test_round_robin;
        logic [NREQ-1:0] g; logic [ID_W-1:0] id; logic [CNT_W-1:0] c; logic [W-1:0] m; int lat; logic ok;
        int exp_a [4] = '{0, 2, 0, 2};
        int exp_b [5] = '{0, 1, 2, 3, 0};
        int rc; logic [W-1:0] rm;
        apply_reset;
        for (int i = 0; i < NREQ; i++) set_word(i, 16'($urandom));
        for (int n = 0; n < 4; n++) begin
            run_word(4'b0101, 1'b1, g, id, c, m, lat, ok);
            ref_scan(req_data[exp_a[n]*W +: W], rc, rm);
            n_checks++; if ({ok, g} !== {1'b1, 4'(1 << exp_a[n])}) begin n_fail++; $display("FAIL rr_0101 step %0d grant got=%b exp onehot %0d", n, g, exp_a[n]); end
            n_checks++; if ({id, c, m} !== {2'(exp_a[n]), 5'(rc), rm}) begin n_fail++; $display("FAIL rr_0101_result step %0d got id=%0d cnt=%0d mask=%h exp %0d/%0d/%h", n, id, c, m, exp_a[n], rc, rm); end
        end
        apply_reset;
        for (int i = 0; i < NREQ; i++) set_word(i, 16'($urandom));
        for (int n = 0; n < 5; n++) begin
            run_word(4'b1111, 1'b1, g, id, c, m, lat, ok);
            n_checks++; if (!ok || !$onehot(g) || g !== 4'(1 << exp_b[n]) || id !== 2'(exp_b[n])) begin n_fail++; $display("FAIL rr_1111 step %0d grant got=%b id=%0d exp id %0d", n, g, id, exp_b[n]); end
        end
        req_valid = '0;
    endtask

    task automatic test_random;
        logic [NREQ-1:0] g; logic [ID_W-1:0] id; logic [CNT_W-1:0] c; logic [W-1:0] m; int lat; logic ok;
        logic [NREQ-1:0] v; logic [W-1:0] w; int e, rc; logic [W-1:0] rm;
        apply_reset;
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                w = 16'($urandom);
                if ($urandom_range(0, 1) == 1) w[$urandom_range(0, W-5) +: 5] = 5'b10110;
                set_word(i, w);
            end
            v = 4'($urandom_range(1, 15));
            e = ref_grant(v, model_ptr);
            ref_scan(req_data[e*W +: W], rc, rm);
            run_word(v, 1'b1, g, id, c, m, lat, ok);
            req_valid = '0;
            model_ptr = (e + 1) % NREQ;
            n_checks++; if ({ok, g, id} !== {1'b1, 4'(1 << e), 2'(e)}) begin n_fail++; $display("FAIL rand_grant #%0d v=%b got g=%b id=%0d exp id %0d", n, v, g, id, e); end
            n_checks++; if (c !== 5'(rc)) begin n_fail++; $display("FAIL rand_count #%0d got=%0d exp=%0d", n, c, rc); end
            n_checks++; if (m !== rm) begin n_fail++; $display("FAIL rand_mask #%0d got=%h exp=%h", n, m, rm); end
            n_checks++; if (lat != 18) begin n_fail++; $display("FAIL rand_latency #%0d got=%0d exp=18", n, lat); end
            repeat ($urandom_range(0, 2)) tick;
        end
    endtask

    task automatic test_backpressure;
        logic [NREQ-1:0] g; logic [ID_W-1:0] id; logic [CNT_W-1:0] c; logic [W-1:0] m; int lat; logic ok;
        int rc; logic [W-1:0] rm;
        apply_reset;
        for (int i = 0; i < NREQ; i++) set_word(i, 16'($urandom));
        set_word(1, 16'hB6B6);
        ref_scan(16'hB6B6, rc, rm);
        run_word(4'b0010, 1'b0, g, id, c, m, lat, ok);
        n_checks++; if ({ok, id, c, m} !== {1'b1, 2'd1, 5'(rc), rm}) begin n_fail++; $display("FAIL bp_result got ok=%b id=%0d cnt=%0d mask=%h exp 1/1/%0d/%h", ok, id, c, m, rc, rm); end
        req_valid = 4'b1111;
        for (int n = 0; n < 10; n++) begin
            tick;
            n_checks++;
            if ({res_valid, res_id, res_count, res_mask, req_ready} !== {1'b1, id, c, m, 4'b0000}) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d got v=%b id=%0d cnt=%0d mask=%h rdy=%b", n, res_valid, res_id, res_count, res_mask, req_ready);
            end
        end
        res_ready = 1'b1;
        tick;
        n_checks++; if ({res_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL bp_release got valid=%b busy=%b exp 0/0", res_valid, busy); end
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_next_grant got=%b exp=0100", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_reset_midword;
        int seen;
        apply_reset;
        set_word(2, 16'hB600);
        req_valid = 4'b0100;
        res_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL mid_grant got=%b exp=0100", req_ready); end
        tick;
        req_valid = '0;
        repeat (7) tick;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got=%b exp=1", busy); end
        rst = 1'b1;
        tick;
        n_checks++; if ({busy, res_valid, req_ready} !== 6'b0) begin n_fail++; $display("FAIL mid_reset_state got busy=%b valid=%b rdy=%b exp 0", busy, res_valid, req_ready); end
        n_checks++; if ({res_id, res_count, res_mask} !== '0) begin n_fail++; $display("FAIL mid_reset_fields got id=%0d cnt=%0d mask=%h exp 0", res_id, res_count, res_mask); end
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 30; n++) begin
            tick;
            if (res_valid) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL mid_no_result got %0d valid cycles exp 0", seen); end
        req_valid = 4'b1111;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_rr_ptr got=%b exp=0001", req_ready); end
        req_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b0;
        test_reset;
        test_vectors;
        test_cross_word;
        test_round_robin;
        test_random;
        test_backpressure;
        test_reset_midword;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
